// File: rtl/rv32i_dmem_responder.sv
// RV32I MEM-stage data memory responder: word-organised SRAM with programmable
// wait states, byte/half/word load-store, sign/zero extension and access checks.
module rv32i_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_re_i,
  input  logic        req_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        re_q;
  logic        we_q;
  logic [AW-1:0] idx_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word;
  logic        bad;
  logic        unused_addr;

  // Rejects misaligned halves/words, undefined funct3 and simultaneous load+store.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] lane,
                                      input logic re, input logic we);
    logic b;
    b = 1'b0;
    case (f3)
      3'b000:  b = 1'b0;
      3'b001:  b = lane[0];
      3'b010:  b = (lane != 2'b00);
      3'b100:  b = we;
      3'b101:  b = we | lane[0];
      default: b = 1'b1;
    endcase
    return b | (re & we);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b010:  r = word;
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Byte-enable merge: lanes not covered by the store keep the old word's bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    case (f3)
      3'b000: begin
        case (lane)
          2'b00:   m[7:0]   = wd[7:0];
          2'b01:   m[15:8]  = wd[7:0];
          2'b10:   m[23:16] = wd[7:0];
          2'b11:   m[31:24] = wd[7:0];
          default: m = old;
        endcase
      end
      3'b001: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      3'b010:  m = wd;
      default: m = old;
    endcase
    return m;
  endfunction

  assign unused_addr = ^addr_i[31:AW+2];
  assign rd_word     = mem[idx_q];
  assign bad         = access_bad(funct3_q, lane_q, re_q, we_q);

  // Stall while a request is being accepted or waiting; released in RESP.
  always_comb begin
    busy_o = 1'b0;
    if (state == S_IDLE) begin
      busy_o = req_re_i | req_we_i;
    end else if (state == S_WAIT) begin
      busy_o = 1'b1;
    end else begin
      busy_o = 1'b0;
    end
  end

  // Control FSM with request capture and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rdata_o  <= 32'd0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_re_i | req_we_i) begin
            re_q     <= req_re_i;
            we_q     <= req_we_i;
            idx_q    <= addr_i[AW+1:2];
            lane_q   <= addr_i[1:0];
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (bad) begin
            err_o <= 1'b1;
            if (re_q) rdata_o <= 32'd0;
          end else if (re_q) begin
            rdata_o  <= load_ext(rd_word, funct3_q, lane_q);
            rvalid_o <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // SRAM write port; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (resetn_i && state == S_RESP && we_q && !re_q && !bad) begin
      mem[idx_q] <= store_merge(rd_word, wdata_q, funct3_q, lane_q);
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: one instance with two wait states,
// one with none; expected responses are queued at issue and popped at response.
module tb_rv32i_dmem_responder;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rstn   [2];
  logic        re_a   [2];
  logic        we_a   [2];
  logic [31:0] addr_a [2];
  logic [31:0] wd_a   [2];
  logic [2:0]  f3_a   [2];
  logic [31:0] rd_a   [2];
  logic        rv_a   [2];
  logic        busy_a [2];
  logic        err_a  [2];

  exp_t        sb[$];
  logic [31:0] last_rd [2];
  int          nvec;
  int          nmis;

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk_i(clk), .resetn_i(rstn[0]), .req_re_i(re_a[0]), .req_we_i(we_a[0]),
    .addr_i(addr_a[0]), .wdata_i(wd_a[0]), .funct3_i(f3_a[0]),
    .rdata_o(rd_a[0]), .rvalid_o(rv_a[0]), .busy_o(busy_a[0]), .err_o(err_a[0])
  );

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .resetn_i(rstn[1]), .req_re_i(re_a[1]), .req_we_i(we_a[1]),
    .addr_i(addr_a[1]), .wdata_i(wd_a[1]), .funct3_i(f3_a[1]),
    .rdata_o(rd_a[1]), .rvalid_o(rv_a[1]), .busy_o(busy_a[1]), .err_o(err_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the response cycle.
  task automatic access(input int d, input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic eerr, input logic [31:0] erd);
    int   w;
    exp_t e;
    w = (d == 0) ? 2 : 0;
    e.err    = eerr;
    e.rvalid = re & ~we & ~eerr;
    if (re) begin
      e.rdata   = eerr ? 32'd0 : erd;
      last_rd[d] = e.rdata;
    end else begin
      e.rdata = last_rd[d];
    end
    sb.push_back(e);
    re_a[d] = re; we_a[d] = we; addr_a[d] = addr; wd_a[d] = wdata; f3_a[d] = f3;
    #1;
    chk1("busy_req", busy_a[d], 1'b1);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk1("busy_wait", busy_a[d], 1'b1);
      chk1("rvalid_wait", rv_a[d], 1'b0);
    end
    @(negedge clk);
    re_a[d] = 1'b0; we_a[d] = 1'b0;
    chk1("busy_resp", busy_a[d], 1'b0);
    chk1("rvalid_resp", rv_a[d], 1'b0);
    chk1("err_resp", err_a[d], 1'b0);
    @(negedge clk);
    e = sb.pop_front();
    chk1("rvalid", rv_a[d], e.rvalid);
    chk1("err", err_a[d], e.err);
    chk32("rdata", rd_a[d], e.rdata);
  endtask

  initial begin
    nvec = 0; nmis = 0;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; re_a[i] = 1'b0; we_a[i] = 1'b0;
      addr_a[i] = 32'd0; wd_a[i] = 32'd0; f3_a[i] = 3'd0; last_rd[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk32("rst_rdata", rd_a[i], 32'd0);
      chk1("rst_rvalid", rv_a[i], 1'b0);
      chk1("rst_err", err_a[i], 1'b0);
      chk1("rst_busy", busy_a[i], 1'b0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(negedge clk);

    // Two wait states: basic word store/load, byte merge, extensions.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0,        3'b010, 1'b0, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, 1'b0, 32'd0);
    access(0, 1'b0, 1'b1, 32'h22, 32'h000000AA, 3'b000, 1'b0, 32'd0);
    access(0, 1'b1, 1'b0, 32'h20, 32'd0,        3'b010, 1'b0, 32'h11AA3344);
    access(0, 1'b0, 1'b1, 32'h30, 32'h00008080, 3'b010, 1'b0, 32'd0);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b000, 1'b0, 32'hFFFFFF80);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b100, 1'b0, 32'h00000080);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b001, 1'b0, 32'hFFFF8080);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b101, 1'b0, 32'h00008080);
    access(0, 1'b1, 1'b0, 32'h22, 32'd0, 3'b000, 1'b0, 32'hFFFFFFAA);

    // Rejected accesses leave memory untouched.
    access(0, 1'b1, 1'b0, 32'h32, 32'd0,        3'b010, 1'b1, 32'd0);
    access(0, 1'b0, 1'b1, 32'h31, 32'h0000FFFF, 3'b001, 1'b1, 32'd0);
    access(0, 1'b1, 1'b1, 32'h30, 32'd0,        3'b010, 1'b1, 32'd0);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0,        3'b010, 1'b0, 32'h00008080);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0,        3'b011, 1'b1, 32'd0);
    access(0, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 3'b100, 1'b1, 32'd0);
    access(0, 1'b1, 1'b0, 32'h30, 32'd0,        3'b010, 1'b0, 32'h00008080);

    // Reset during a wait state drops the pending store.
    access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 3'b010, 1'b0, 32'd0);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0,        3'b010, 1'b0, 32'h12345678);
    re_a[0] = 1'b0; we_a[0] = 1'b1; addr_a[0] = 32'h40; wd_a[0] = 32'h5; f3_a[0] = 3'b010;
    @(negedge clk);
    chk1("busy_before_rst", busy_a[0], 1'b1);
    rstn[0] = 1'b0; we_a[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    #1;
    chk32("rst2_rdata", rd_a[0], 32'd0);
    chk1("rst2_rvalid", rv_a[0], 1'b0);
    chk1("rst2_err", err_a[0], 1'b0);
    chk1("rst2_busy", busy_a[0], 1'b0);
    last_rd[0] = 32'd0;
    @(negedge clk);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0, 3'b010, 1'b0, 32'h12345678);

    // No wait states: back-to-back accesses and address aliasing.
    access(1, 1'b0, 1'b1, 32'h0,    32'hCAFEF00D, 3'b010, 1'b0, 32'd0);
    access(1, 1'b0, 1'b1, 32'h4,    32'h01020304, 3'b010, 1'b0, 32'd0);
    access(1, 1'b1, 1'b0, 32'h0,    32'd0,        3'b010, 1'b0, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h4,    32'd0,        3'b010, 1'b0, 32'h01020304);
    access(1, 1'b1, 1'b0, 32'h1000, 32'd0,        3'b010, 1'b0, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h7, 32'd0, 3'b100, 1'b0, 32'h00000001);
    @(negedge clk);
    chk1("rvalid_pulse_end", rv_a[1], 1'b0);
    chk32("rdata_hold", rd_a[1], 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
